// File: rtl/if_id_queue.sv
// IF/ID boundary with a 2-entry skid queue: absorbs ROM words already in flight while ID is
// stalled, so a held PC never loses or duplicates a fetched instruction.
`ifndef CTRL_WIDTH
`define CTRL_WIDTH 3
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_DATA_WIDTH
`define INST_DATA_WIDTH 32
`endif

module if_id_queue #(
    parameter logic [`INST_DATA_WIDTH-1:0] NOP_INST = 32'h0000_0000,
    parameter logic [`INST_ADDR_WIDTH-1:0] NOP_PC   = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [`CTRL_WIDTH-1:0]      stall,
    input  logic                        flush,
    input  logic                        pc_enable,
    input  logic [`INST_ADDR_WIDTH-1:0] pc_in,
    input  logic [`INST_DATA_WIDTH-1:0] rom_data,
    output logic [`INST_ADDR_WIDTH-1:0] id_pc,
    output logic [`INST_DATA_WIDTH-1:0] id_inst,
    output logic                        stallreq_if,
    output logic [1:0]                  q_count
);

    logic                        req_v;
    logic [`INST_ADDR_WIDTH-1:0] req_pc;
    logic [`INST_ADDR_WIDTH-1:0] q_pc   [2];
    logic [`INST_DATA_WIDTH-1:0] q_inst [2];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  count;
    logic [1:0]                  count_next;

    logic push;
    logic pop_ok;
    logic pop;
    logic bypass;
    logic wr_en;

    always_comb begin
        push   = req_v & ~flush;
        pop_ok = ~stall[1] & ~flush;
        pop    = pop_ok & (count != 2'd0);
        bypass = push & pop_ok & (count == 2'd0);
        // A full queue only accepts a word when the head leaves in the same cycle.
        wr_en  = push & ~bypass & ((count != 2'd2) | pop);
    end

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            count_next = count + {1'b0, wr_en} - {1'b0, pop};
        end
    end

    assign stallreq_if = (count_next == 2'd2);
    assign q_count     = count;

    // Queue storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_pc[wr_ptr]   <= req_pc;
            q_inst[wr_ptr] <= rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_v  <= 1'b0;
            req_pc <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            req_v  <= pc_enable & ~stall[0] & ~flush;
            req_pc <= pc_in;
            count  <= count_next;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (wr_en) wr_ptr <= ~wr_ptr;
                if (pop)   rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc   <= NOP_PC;
            id_inst <= NOP_INST;
        end else if (flush) begin
            id_pc   <= NOP_PC;
            id_inst <= NOP_INST;
        end else if (stall[1] && !stall[2]) begin
            id_pc   <= NOP_PC;
            id_inst <= NOP_INST;
        end else if (stall[1]) begin
            id_pc   <= id_pc;
            id_inst <= id_inst;
        end else if (pop) begin
            id_pc   <= q_pc[rd_ptr];
            id_inst <= q_inst[rd_ptr];
        end else if (bypass) begin
            id_pc   <= req_pc;
            id_inst <= rom_data;
        end else begin
            id_pc   <= NOP_PC;
            id_inst <= NOP_INST;
        end
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0000: instruction word inserted as a bubble.
REQ-002 SHALL have parameter NOP_PC, default 0: pc value inserted with a bubble.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 stall  input  `CTRL_WIDTH  pipeline stall vector; bit0 = PC hold, bit1 = IF hold, bit2 = ID hold.
REQ-007 flush  input  1  kill all fetched-but-unissued instructions this cycle.
REQ-008 pc_enable  input  1  PC stage running; fetch acceptance is gated by it.
REQ-009 pc_in  input  `INST_ADDR_WIDTH  address presented to the ROM this cycle.
REQ-010 rom_data  input  `INST_DATA_WIDTH  synchronous ROM output; valid one cycle after its address.
REQ-011 id_pc  output  `INST_ADDR_WIDTH  registered pc to ID.
REQ-012 id_inst  output  `INST_DATA_WIDTH  registered instruction to ID.
REQ-013 stallreq_if  output  1  combinational request to the stall controller to hold the PC.
REQ-014 q_count  output  2  current queue occupancy, 0..2.

Function
REQ-015 Fetch accept: in cycle t, when pc_enable=1, stall[0]=0 and flush=0; SHALL register req_v<=1 and req_pc<=pc_in; otherwise req_v<=0.
REQ-016 Push: in cycle t+1, when req_v=1 and flush=0; SHALL write {req_pc, rom_data} at the queue tail.
REQ-017 Queue: 2-entry FIFO, in-order, pointer wrap modulo 2; count_next = count + push - pop.
REQ-018 Pop: when stall[1]=0, flush=0 and count>0; SHALL remove the head.
REQ-019 Empty bypass: when count=0 and push and pop conditions hold; data SHALL pass directly to the output register, leaving count at 0.
REQ-020 Output register, priority order:
- flush=1 -> load {NOP_PC, NOP_INST}.
- stall[1]=1 and stall[2]=0 -> load bubble.
- stall[1]=1 and stall[2]=1 -> hold.
- stall[1]=0 with data available (head or bypass) -> load it.
- stall[1]=0 with no data -> load bubble.
REQ-021 stallreq_if SHALL equal (count_next == 2).
REQ-022 Consequence of REQ-021: a push into a full queue SHALL never occur; simultaneous push and pop when full SHALL leave count at 2.
REQ-023 flush SHALL, in the same edge, clear count, both pointers and req_v, and discard rom_data arriving that cycle.
REQ-024 Latency: an address accepted at cycle t SHALL appear on id_pc/id_inst after the edge ending cycle t+1, given no stall and an empty queue.
REQ-025 Ordering: every accepted, unflushed fetch SHALL reach ID exactly once, in address order; no duplicates under stall.

Reset
REQ-026 When rst_n=0, asynchronously and regardless of clk:
- count=0, pointers=0, req_v=0
- id_pc=NOP_PC, id_inst=NOP_INST
- stallreq_if=0
REQ-027 Mid-operation reset SHALL discard queue contents; the first post-reset push SHALL be the first fetch accepted after rst_n rises.

Verification
REQ-028 Streaming: pc 0,4,8 accepted over consecutive cycles, no stall -> id_pc 0,4,8 one cycle after each ROM word; q_count stays 0.
REQ-029 ID backpressure: stall[1]=stall[2]=1 for 3 cycles while fetching 0x10,0x14 -> q_count reaches 2, stallreq_if=1; id outputs held; after release, outputs 0x10 then 0x14 with no loss.
REQ-030 Bubble: stall[1]=1, stall[2]=0 for 1 cycle -> id_inst=NOP_INST, id_pc=NOP_PC; next instruction follows in order after release.
REQ-031 Flush: q_count=2 plus a fetch in flight, flush=1 -> next cycle q_count=0, id_inst=NOP_INST; in-flight word never issued.
REQ-032 Async reset: rst_n low between clock edges while q_count=2 -> q_count=0 and id_pc=NOP_PC immediately, before the next edge.
